// File: rtl/string_detect_session_ctrl_if.sv
// Serial bit stream handshake between a bit source (master) and the session controller (slave).
interface string_detect_session_ctrl_if;
  logic bit_valid;
  logic bit_in;
  logic bit_ready;

  modport master (output bit_valid, output bit_in, input bit_ready);
  modport slave  (input bit_valid, input bit_in, output bit_ready);
endinterface

// File: rtl/string_detect_session_ctrl.sv
// Bounded pattern-detection session: latches pattern/length/mode on start, pulls frame_len
// serial bits, counts (optionally overlapping) matches into a saturating N, then pulses done.
module string_detect_session_ctrl #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PAT_W-1:0]     pattern,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 overlap,
  string_detect_session_ctrl_if.slave bit_bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     N,
  output logic                 overflow
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MATCH = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  N_MAX      = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [PAT_W-2:0]   sr;
  logic [FILL_W-1:0]  fill;
  logic [LEN_W-1:0]   rcvd;
  logic               ready;
  logic               accept;
  logic               last_bit;
  logic               match;
  logic [PAT_W-1:0]   window;

  // Only the newest PAT_W-1 bits are kept; the incoming bit completes the compare window.
  assign window   = {sr, bit_bus.bit_in};
  assign accept   = ready & bit_bus.bit_valid;
  assign match    = (fill >= FILL_MATCH) && (window == pat_q);
  assign last_bit = (rcvd + LEN_W'(1)) == len_q;
  assign bit_bus.bit_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (frame_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          ready = 1'b1;
          if (bit_bus.bit_valid && last_bit) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Non-overlapping mode forces a full refill of the window after every match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      sr       <= '0;
      fill     <= '0;
      rcvd     <= '0;
      N        <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      pat_q    <= pattern;
      len_q    <= frame_len;
      ovl_q    <= overlap;
      sr       <= '0;
      fill     <= '0;
      rcvd     <= '0;
      N        <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      sr   <= window[PAT_W-2:0];
      rcvd <= rcvd + LEN_W'(1);
      if (match) begin
        if (N == N_MAX) overflow <= 1'b1;
        else            N        <= N + CNT_W'(1);
        if (!ovl_q) fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: doc/string_detect_session_ctrl.md
# string_detect_session_ctrl

Sequences one serial pattern-detection session. It latches a PAT_W-bit pattern, a frame length and an overlap mode on `start`, then pulls exactly `frame_len` serial bits through a valid/ready handshake. It counts pattern occurrences into `N`, raises a one-cycle `done`, and returns to idle. It sits between the serial bit source and the consumer of the match count, and replaces free-running detection with bounded, restartable sessions.

## Interface
- `PAT_W`, 4: pattern width in bits (≥2)
- `LEN_W`, 8: frame-length counter width
- `CNT_W`, 4: match-count width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin session; sampled only in IDLE
- `abort` in 1: terminate RUN session; no `done`
- `pattern` in PAT_W: target pattern, MSB = first bit received; latched on start
- `frame_len` in LEN_W: number of bits in session; latched on start
- `overlap` in 1: 1 = overlapping matches counted, 0 = window restarts after a match; latched on start
- `bit_valid` in 1: source has a bit
- `bit_in` in 1: serial data bit
- `bit_ready` out 1: controller accepts a bit this cycle
- `busy` out 1: session in progress (RUN or DONE)
- `done` out 1: one-cycle pulse, session complete
- `N` out CNT_W: match count, saturating
- `overflow` out 1: a match occurred while `N` was at its maximum

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `bit_ready`=0, `busy`=0. On `start`=1:
  - latch `pattern`, `frame_len` and `overlap`
  - clear the shift register, fill count, received count, `N` and `overflow`
  - go to RUN, or go to DONE if `frame_len`=0
- RUN: `bit_ready`=1, `busy`=1.
  - A bit is accepted when `bit_valid`&`bit_ready`.
  - On accept, the shift register shifts left with `bit_in` entering at the LSB, and the fill count increments, saturating at PAT_W.
  - Match is true when fill count ≥ PAT_W-1 before the shift and {sr[PAT_W-2:0], `bit_in`} == latched pattern.
  - On a match with `N` < max, `N`+1. On a match with `N` = max, `N` holds and `overflow` is set.
  - On a match with `overlap`=0, the fill count is cleared to 0 (shift register contents are ignored until refilled). With `overlap`=1, the fill count is unchanged.
  - The accepted bit that makes the received count equal the latched `frame_len` moves the FSM to DONE.
  - `abort`=1 → IDLE immediately. `N` and `overflow` keep their partial values and no `done` is issued. `abort` takes priority over a same-cycle accept: that bit is not accepted (`bit_ready` is forced to 0 in that cycle).
- DONE: `done`=1, `busy`=1, `bit_ready`=0; unconditionally → IDLE next cycle.
- `start` is ignored outside IDLE. `abort` is ignored outside RUN.
- `N` and `overflow` hold their values from the end of a session until the next accepted `start`.

## Timing
- Reset values: `bit_ready`=0, `busy`=0, `done`=0, `N`=0, `overflow`=0, state IDLE. Reset is asynchronous and may assert mid-session; the session is discarded.
- `start` sampled at edge t → `busy`=1 and `bit_ready`=1 from t+1.
- `bit_ready` is a registered function of state only. It never depends combinationally on `bit_valid`; only `abort` gates it combinationally.
- A match on the bit accepted at edge k makes `N` updated visible after k.
- Last bit accepted at edge k → `done`=1 in cycle k+1 → IDLE (and `busy`=0) from k+2. The earliest next `start` is sampled at edge k+2.
- `frame_len`=0: `start` at t → `done` in cycle t+1, `N`=0.
- Throughput: one bit per cycle while `bit_valid` is held high. Gaps in `bit_valid` only stretch the session.

## Test plan
- Pattern 0110, `overlap`=1, `frame_len`=10, stream 0,1,1,0,0,1,1,0,0,0 with `bit_valid` held high → `N`=2, `done` one cycle after the 10th bit, `overflow`=0.
- Pattern 0101, stream 0,1,0,1,0,1, `frame_len`=6 → `overlap`=1 gives `N`=2; rerun with `overlap`=0 gives `N`=1.
- Pattern 0000, `overlap`=1, 20 zero bits → matches on bits 4..20 (17 matches) → `N`=15, `overflow`=1.
- Same stream as the first case with `bit_valid` low every other cycle → `N`=2. Exactly 10 accepts, `bit_ready` never drops during RUN, and `done` timing follows the last accept.
- `frame_len`=0 → `done` in the cycle after `start`, `N`=0. `start` pulsed during RUN and during DONE → ignored, with no change to the latched length or pattern.
- `abort` after 5 bits of the first case → IDLE next cycle, no `done`, `N`=1. Separately, `rst_n` pulsed low mid-RUN → all outputs at reset values asynchronously, and a fresh session afterwards counts correctly.
